lsu_mem_initiator: RTL and testbench
====================================

// Module: lsu_mem_initiator
// PURPOSE
//  Load/store initiator between the RV32I datapath and the 32x32 word data memory.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Handles LB/LH/LW/LBU/LHU/SB/SH/SW, using read-modify-write for sub-word stores.
//  Returns the sign- or zero-extended load data, or an error flag, over a valid/ready response.
// PARAMETERS
//  MEM_WORDS  32  words in data memory; legal word index range is 0..MEM_WORDS-1
//  XLEN       32  data and address width
// PORTS
//  CLK         in   1     single clock, rising edge
//  RST         in   1     asynchronous, active-high reset
//  req_valid   in   1     request present
//  req_ready   out  1     high only in IDLE
//  req_funct3  in   3     RV32I load/store funct3
//  req_store   in   1     1=store, 0=load
//  req_addr    in   XLEN  byte address
//  req_wdata   in   XLEN  store data, right-aligned
//  resp_valid  out  1     response present
//  resp_ready  in   1     response consumed
//  resp_rdata  out  XLEN  load result; 0 for stores and errors
//  resp_err    out  1     misaligned or out-of-range access
//  mem_we      out  1     memory write enable (memory writes on the next CLK edge)
//  mem_a       out  XLEN  word index = addr_q[XLEN-1:2]
//  mem_wd      out  XLEN  memory write data
//  mem_rd      in   XLEN  memory read data, combinational from mem_a
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_a=0; mem_wd=0.
//  Handshake and latching:
//   - Request accepted on the edge where req_valid & req_ready.
//   - funct3, store, addr and wdata are latched at acceptance; inputs are ignored afterwards.
//  Error is checked at acceptance and wins over any access:
//   - H misaligned when addr[0]=1; W misaligned when addr[1:0]!=0.
//   - Word index >= MEM_WORDS is out of range.
//   - Undefined funct3 (011, 110, 111; or 100/101 with a store) is an error.
//   - On error: go to RESP with resp_err=1 and resp_rdata=0; mem_we is never asserted.
//  States (outputs registered or decoded from state only; mem_we=1 only in WRITE):
//   - IDLE:  req_ready=1. On accept: error -> RESP; load -> LOAD; SW -> WRITE with wd=wdata; SB/SH -> MERGE.
//   - LOAD:  drive mem_a; sample mem_rd; select byte or half by addr[1:0]; sign- or zero-extend into resp_rdata -> RESP.
//   - MERGE: drive mem_a; replace byte lane addr[1:0] or half lane addr[1] of mem_rd with low bits of wdata into wd_q -> WRITE.
//   - WRITE: mem_we=1, mem_a=index, mem_wd=wd_q for exactly one cycle -> RESP.
//   - RESP:  resp_valid=1, outputs held stable; on resp_ready -> IDLE.
//  Response latency from the accept edge (resp_ready tied 1):
//   - error: 1 cycle; LW/LB/SW: 2 cycles; SB/SH: 3 cycles.
//  Throughput: the next request is accepted at the earliest in the cycle after the response is consumed; no overlap.
//  Asserting RST in any state returns the block to IDLE immediately:
//   - mem_we drops asynchronously, so no partial write reaches memory.
//   - A merge in progress is discarded; no response is issued.
//  Memory reset is independent of this block. A request issued during memory reset sees reads of 0.
//  Arithmetic: byte lane = addr[1:0]; half lane = addr[1]. mem_a upper bits are zero-extended and never wrap.
// STRUCTURE
//  Shared package lsu_pkg:
//   - funct3 localparams F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
//   - State encoding IDLE/LOAD/MERGE/WRITE/RESP.
//  Sub-module lsu_align (purely combinational):
//   - Load path: extract and extend from a word using funct3 and addr[1:0].
//   - Store path: merge wdata into a word.
//   - Instantiated once; the FSM holds all state.
// TESTING
//  Bench pairs this block with the 32-word data memory model; resp_ready=1 unless stated.
//  1) SW addr=0x08, wdata=0xDEADBEEF, then LW 0x08 -> resp_rdata=0xDEADBEEF; SW response 2 cycles after accept.
//  2) SB 0x09, wdata=0x80 into word 0x11223344; LB 0x09 -> 0xFFFFFF80; LBU 0x09 -> 0x00000080; word reads 0x11228044.
//  3) SH 0x0E, wdata=0xABCD over 0 -> word 3 = 0xABCD0000; LH 0x0E -> 0xFFFFABCD; SH response 3 cycles after accept.
//  4) LW 0x06, SH 0x05 and LW 0x80 (index 32) -> resp_err=1, rdata=0, mem_we never high, memory unchanged.
//  5) resp_ready held 0 for 4 cycles -> resp_valid/rdata stable, req_ready=0; a new req_valid is not accepted.
//  6) RST pulsed during MERGE of SB 0x00 -> mem_we never asserted; word 0 unchanged; outputs at reset values; next LW works.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared funct3 codes and FSM state encoding for the load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Brief  : Combinational lane extraction/extension for loads and lane merge
//          for sub-word stores.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = word[{lane, 3'b000} +: 8];
    w_half    = lane[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   load_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   load_data = word;
      default: load_data = '0;
    endcase
  end

  // Only the low byte/half of wdata is used for sub-word stores
  always_comb begin
    merge_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        merge_data                          = word;
        merge_data[{lane, 3'b000} +: 8]     = wdata[7:0];
      end
      2'b01: begin
        merge_data                          = word;
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
// ============================================================================
// Module : lsu_mem_initiator
// Brief  : Single-outstanding load/store initiator to a word-addressed data
//          memory, with read-modify-write for SB/SH.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int XLEN      = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_store,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  localparam logic [XLEN-1:0] c_mem_words = XLEN'(MEM_WORDS);

  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic [2:0]      r_f3;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_mem_a;
  logic [XLEN-1:0] r_wd;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_oor;
  logic            w_f3_bad;
  logic            w_misal;
  logic            w_err;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merge_data;

  always_comb begin
    w_oor    = {2'b00, req_addr[XLEN-1:2]} >= c_mem_words;
    w_misal  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_f3_bad = 1'b1;
    case (req_funct3)
      F3_LB, F3_LH, F3_LW: w_f3_bad = 1'b0;
      F3_LBU, F3_LHU:      w_f3_bad = req_store;
      default:             w_f3_bad = 1'b1;
    endcase
    w_err = w_oor || w_misal || w_f3_bad;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_err)               w_next = ST_RESP;
          else if (!req_store)     w_next = ST_LOAD;
          else if (req_funct3 == F3_LW) w_next = ST_WRITE;
          else                     w_next = ST_MERGE;
        end
      end
      ST_LOAD:  w_next = ST_RESP;
      ST_MERGE: w_next = ST_WRITE;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  if (resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_wd carries the raw store data until MERGE replaces it with the merged word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_f3    <= '0;
      r_lane  <= '0;
      r_mem_a <= '0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_f3    <= req_funct3;
            r_lane  <= req_addr[1:0];
            r_mem_a <= {2'b00, req_addr[XLEN-1:2]};
            r_wd    <= req_wdata;
            r_rdata <= '0;
            r_err   <= w_err;
          end
        end
        ST_LOAD:  r_rdata <= w_load_data;
        ST_MERGE: r_wd    <= w_merge_data;
        default: ;
      endcase
    end
  end

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3     (r_f3),
    .lane       (r_lane),
    .word       (mem_rd),
    .wdata      (r_wd),
    .load_data  (w_load_data),
    .merge_data (w_merge_data)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign mem_we     = (r_state == ST_WRITE);
  assign mem_a      = r_mem_a;
  assign mem_wd     = r_wd;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
// ============================================================================
// Module : tb_lsu_mem_initiator
// Brief  : Directed vector bench for lsu_mem_initiator with a 32-word memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_initiator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic        mem_clr;
  logic [31:0] mem [32];
  int          we_cnt = 0;
  int          total  = 0;
  int          bad    = 0;

  lsu_mem_initiator #(.MEM_WORDS(32), .XLEN(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 CLK = ~CLK;

  assign mem_rd = (mem_a < 32) ? mem[mem_a[4:0]] : 32'h0;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int j = 0; j < 32; j++) mem[j] <= 32'h0;
    end else if (mem_we && (mem_a < 32)) begin
      mem[mem_a[4:0]] <= mem_wd;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  typedef struct {
    logic [2:0]  f3;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [2:0] f3, input logic st, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
    vt[i].f3 = f3; vt[i].st = st; vt[i].addr = a; vt[i].wd = wd;
    vt[i].exp_rd = rd; vt[i].exp_err = er; vt[i].exp_lat = lat;
  endtask

  // Issues one request with resp_ready=1; inputs are scrambled after accept
  task automatic txn(input logic [2:0] f3, input logic st, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge CLK);
    req_funct3 = f3; req_store = st; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0; req_funct3 = ~f3; req_store = ~st; req_addr = ~a; req_wdata = ~wd;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata;
    er = resp_err;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we0;
    int          n;

    setv( 0, 3'b010, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    setv( 1, 3'b010, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    setv( 2, 3'b010, 1'b1, 32'h08, 32'h11223344, 32'h0,        1'b0, 2);
    setv( 3, 3'b000, 1'b1, 32'h09, 32'h00000080, 32'h0,        1'b0, 3);
    setv( 4, 3'b000, 1'b0, 32'h09, 32'h0,        32'hFFFFFF80, 1'b0, 2);
    setv( 5, 3'b100, 1'b0, 32'h09, 32'h0,        32'h00000080, 1'b0, 2);
    setv( 6, 3'b010, 1'b0, 32'h08, 32'h0,        32'h11228044, 1'b0, 2);
    setv( 7, 3'b000, 1'b0, 32'h0B, 32'h0,        32'h00000011, 1'b0, 2);
    setv( 8, 3'b001, 1'b0, 32'h0A, 32'h0,        32'h00001122, 1'b0, 2);
    setv( 9, 3'b001, 1'b1, 32'h0E, 32'h0000ABCD, 32'h0,        1'b0, 3);
    setv(10, 3'b001, 1'b0, 32'h0E, 32'h0,        32'hFFFFABCD, 1'b0, 2);
    setv(11, 3'b101, 1'b0, 32'h0E, 32'h0,        32'h0000ABCD, 1'b0, 2);
    setv(12, 3'b010, 1'b0, 32'h0C, 32'h0,        32'hABCD0000, 1'b0, 2);
    setv(13, 3'b010, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1, 1);
    setv(14, 3'b001, 1'b1, 32'h05, 32'h1234,     32'h0,        1'b1, 1);
    setv(15, 3'b010, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1);
    setv(16, 3'b011, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 1);
    setv(17, 3'b100, 1'b1, 32'h00, 32'h55,       32'h0,        1'b1, 1);
    setv(18, 3'b101, 1'b0, 32'h0D, 32'h0,        32'h0,        1'b1, 1);
    setv(19, 3'b010, 1'b0, 32'h08, 32'h0,        32'h11228044, 1'b0, 2);
    setv(20, 3'b010, 1'b0, 32'h7C, 32'h0,        32'h0,        1'b0, 2);
    setv(21, 3'b010, 1'b1, 32'h7C, 32'h5A5A0001, 32'h0,        1'b0, 2);
    setv(22, 3'b010, 1'b0, 32'h7C, 32'h0,        32'h5A5A0001, 1'b0, 2);
    setv(23, 3'b010, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0, 2);
    setv(24, 3'b000, 1'b1, 32'h0C, 32'hFFFFFF12, 32'h0,        1'b0, 3);
    setv(25, 3'b010, 1'b0, 32'h0C, 32'h0,        32'hABCD0012, 1'b0, 2);

    RST = 1'b1; mem_clr = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_funct3 = 3'b0; req_store = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.resp_rdata", resp_rdata,          32'h0);
    chk("rst.resp_err",   {31'h0, resp_err},   32'h0);
    chk("rst.mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst.mem_a",      mem_a,               32'h0);
    chk("rst.mem_wd",     mem_wd,              32'h0);
    @(negedge CLK);
    RST = 1'b0; mem_clr = 1'b0;

    we0 = 0;
    for (int i = 0; i < 26; i++) begin
      if (i == 13) we0 = we_cnt;
      if (i == 19) chk("err.no_write", we_cnt, we0);
      txn(vt[i].f3, vt[i].st, vt[i].addr, vt[i].wd, rd, er, lat);
      chk($sformatf("v%0d.rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d.err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
      chk($sformatf("v%0d.lat", i), lat, vt[i].exp_lat);
    end
    chk("mem.word2", mem[2], 32'h11228044);
    chk("mem.word3", mem[3], 32'hABCD0012);

    // Backpressure: response held while resp_ready is low; new request ignored
    @(negedge CLK);
    resp_ready = 1'b0;
    req_funct3 = 3'b010; req_store = 1'b0; req_addr = 32'h08; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("hold.valid", {31'h0, resp_valid}, 32'h1);
    @(negedge CLK);
    req_funct3 = 3'b010; req_store = 1'b1; req_addr = 32'h00; req_wdata = 32'h00000BAD; req_valid = 1'b1;
    we0 = we_cnt;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("hold%0d.valid", k), {31'h0, resp_valid}, 32'h1);
      chk($sformatf("hold%0d.rdata", k), resp_rdata, 32'h11228044);
      chk($sformatf("hold%0d.req_ready", k), {31'h0, req_ready}, 32'h0);
    end
    @(negedge CLK);
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("hold.released", {31'h0, resp_valid}, 32'h0);
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("hold.idle", {31'h0, req_ready}, 32'h1);
    chk("hold.no_resp", {31'h0, resp_valid}, 32'h0);
    chk("hold.no_write", we_cnt, we0);
    chk("hold.word0", mem[0], 32'h0);

    // Reset in the middle of a sub-word store merge
    txn(3'b010, 1'b1, 32'h00, 32'hCAFEF00D, rd, er, lat);
    chk("pre6.lat", lat, 2);
    @(negedge CLK);
    req_funct3 = 3'b000; req_store = 1'b1; req_addr = 32'h00; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    we0 = we_cnt;
    #2 RST = 1'b1;
    #1;
    chk("rst6.mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst6.req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst6.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst6.mem_wd",     mem_wd,              32'h0);
    chk("rst6.resp_rdata", resp_rdata,          32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst6.no_write", we_cnt, we0);
    chk("rst6.no_resp",  {31'h0, resp_valid}, 32'h0);
    chk("rst6.word0",    mem[0], 32'hCAFEF00D);
    txn(3'b010, 1'b0, 32'h00, 32'h0, rd, er, lat);
    chk("post6.rdata", rd, 32'hCAFEF00D);
    chk("post6.err",   {31'h0, er}, 32'h0);
    chk("post6.lat",   lat, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
